// File: rtl/tail_encoder_if.sv
// rtl/tail_encoder_if.sv - shift-tail input and UART-side output bundle for tail_encoder
interface tail_encoder_if;
  logic       SHIFT_ENABLE;
  logic       SHIFT_TAIL;
  logic       UART_READY;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       OVERFLOW;

  modport master (
    output SHIFT_ENABLE, SHIFT_TAIL, UART_READY,
    input  OUT_VALID, OUT_DATA, OVERFLOW
  );

  modport slave (
    input  SHIFT_ENABLE, SHIFT_TAIL, UART_READY,
    output OUT_VALID, OUT_DATA, OVERFLOW
  );
endinterface

// File: rtl/tail_encoder.sv
// rtl/tail_encoder.sv - assembles MSB-first serial bits into bytes and queues them for a UART
module tail_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input logic          CLK,
  input logic          RST,
  tail_encoder_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(FIFO_DEPTH);

  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    asm_q, asm_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       push;
  logic       pop;
  logic       full;
  logic       do_write;
  logic [7:0] push_byte;

  assign push_byte = {asm_q[6:0], bus.SHIFT_TAIL};
  assign push      = bus.SHIFT_ENABLE && (bit_cnt_q == 3'd7);
  assign pop       = (count_q != '0) && bus.UART_READY;
  assign full      = (count_q == CNT_MAX);
  // When full, a simultaneous pop frees the slot the write pointer already aims at.
  assign do_write  = push && (!full || pop);

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    asm_d      = asm_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && full && !pop);

    if (bus.SHIFT_ENABLE) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      asm_d     = push_byte;
    end
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({do_write, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_q  <= 3'd0;
      asm_q      <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge CLK) begin
    if (!RST && do_write) mem_q[wr_ptr_q] <= push_byte;
  end

  assign bus.OUT_VALID = (count_q != '0);
  assign bus.OUT_DATA  = bus.OUT_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.OVERFLOW  = overflow_q;
endmodule
